// File: rtl/pacman_movement.sv
// pacman_movement -- Pac-Man position controller.
//
// Buffers one pending turn from the single-cycle direction pulses and, once
// per movement tick, tries to step one pixel: first in the pending direction
// (if any), falling back to the current direction. Every step target is
// checked against the maze through a WallReq/WallAck handshake; targets that
// fall outside the screen are treated as walls without a query.
//
// Optional feature: define PACMAN_TUNNEL_EN to make row Y_INIT a wrap-around
// tunnel (left from X=0 targets X_MAX, right from X_MAX targets 0).
//
// Ports:
//   Clk, Reset (async, active-low)          clock / reset
//   Start                                   leaves INIT when high
//   SCEN_Up/Down/Left/Right                 one-cycle direction requests
//   WallReq, WallX, WallY                   wall query out (held until ack)
//   WallAck, WallHit                        wall query response
//   pacX, pacY, Dir, Moving                 position, direction, step flag
//   Qi, Qw, Qm                              one-hot INIT / wait+query / MOVE
module pacman_movement #(
    parameter int X_INIT      = 320,
    parameter int Y_INIT      = 240,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int TICK_CYCLES = 1000000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       SCEN_Up,
    input  logic       SCEN_Down,
    input  logic       SCEN_Left,
    input  logic       SCEN_Right,
    output logic       WallReq,
    output logic [9:0] WallX,
    output logic [9:0] WallY,
    input  logic       WallAck,
    input  logic       WallHit,
    output logic [9:0] pacX,
    output logic [9:0] pacY,
    output logic [1:0] Dir,
    output logic       Moving,
    output logic       Qi,
    output logic       Qw,
    output logic       Qm
);

    typedef enum logic [2:0] {S_INIT, S_WAIT_TICK, S_QUERY, S_RETRY, S_MOVE} state_t;

    localparam int               CNT_W     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);
    localparam logic [9:0]       X_INIT10  = 10'(X_INIT);
    localparam logic [9:0]       Y_INIT10  = 10'(Y_INIT);
    localparam logic [9:0]       X_MAX10   = 10'(X_MAX);
    localparam logic [9:0]       Y_MAX10   = 10'(Y_MAX);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic [1:0]       pend_dir, try_dir, sel_dir, scen_dir;
    logic             pend_v, scen_any, using_pend, tgt_oor;
    logic [9:0]       step_x, step_y;
    logic             step_oor, query_done, query_hit;

    // Returns {out_of_range, target_x, target_y} for one step in direction d.
    function automatic logic [20:0] step_target(input logic [1:0] d,
                                                input logic [9:0] x,
                                                input logic [9:0] y);
        logic       oor;
        logic [9:0] tx, ty;
        oor = 1'b0;
        tx  = x;
        ty  = y;
        case (d)
            2'b00: if (y == '0) oor = 1'b1; else ty = y - 10'd1;
            2'b01: if (y >= Y_MAX10) oor = 1'b1; else ty = y + 10'd1;
            2'b10: begin
                if (x == '0) begin
`ifdef PACMAN_TUNNEL_EN
                    if (y == Y_INIT10) tx = X_MAX10; else oor = 1'b1;
`else
                    oor = 1'b1;
`endif
                end else begin
                    tx = x - 10'd1;
                end
            end
            default: begin
                if (x >= X_MAX10) begin
`ifdef PACMAN_TUNNEL_EN
                    if (y == Y_INIT10) tx = '0; else oor = 1'b1;
`else
                    oor = 1'b1;
`endif
                end else begin
                    tx = x + 10'd1;
                end
            end
        endcase
        return {oor, tx, ty};
    endfunction

    assign tick = (tick_cnt == TICK_LAST);

    // Simultaneous pulses resolve Up > Down > Left > Right.
    always_comb begin
        scen_any = SCEN_Up | SCEN_Down | SCEN_Left | SCEN_Right;
        if (SCEN_Up)        scen_dir = 2'b00;
        else if (SCEN_Down) scen_dir = 2'b01;
        else if (SCEN_Left) scen_dir = 2'b10;
        else                scen_dir = 2'b11;
    end

    // The pending turn is only offered on a fresh tick; a retry always uses Dir.
    assign sel_dir = (state == S_WAIT_TICK && pend_v) ? pend_dir : Dir;
    assign {step_oor, step_x, step_y} = step_target(sel_dir, pacX, pacY);

    // An out-of-range target resolves as a hit immediately, with no handshake.
    assign query_done = (state == S_QUERY) && (tgt_oor || (WallReq && WallAck));
    assign query_hit  = tgt_oor || WallHit;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= S_INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:      if (Start) state_nxt = S_WAIT_TICK;
            S_WAIT_TICK: if (tick) state_nxt = S_QUERY;
            S_QUERY: begin
                if (query_done) begin
                    if (!query_hit)     state_nxt = S_MOVE;
                    else if (using_pend) state_nxt = S_RETRY;
                    else                state_nxt = S_WAIT_TICK;
                end
            end
            S_RETRY:     state_nxt = S_QUERY;
            S_MOVE:      state_nxt = S_WAIT_TICK;
            default:     state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            tick_cnt   <= '0;
            pend_dir   <= 2'b10;
            pend_v     <= 1'b0;
            try_dir    <= 2'b10;
            using_pend <= 1'b0;
            tgt_oor    <= 1'b0;
            WallReq    <= 1'b0;
            WallX      <= '0;
            WallY      <= '0;
            pacX       <= X_INIT10;
            pacY       <= Y_INIT10;
            Dir        <= 2'b10;
            Moving     <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

            // A new pulse beats consumption in the same cycle.
            if (scen_any) begin
                pend_dir <= scen_dir;
                pend_v   <= 1'b1;
            end else if (state == S_MOVE && using_pend) begin
                pend_v <= 1'b0;
            end

            case (state)
                S_INIT: begin
                    pacX <= X_INIT10;
                    pacY <= Y_INIT10;
                end
                S_WAIT_TICK, S_RETRY: begin
                    if (state == S_RETRY || tick) begin
                        try_dir    <= sel_dir;
                        using_pend <= (state == S_WAIT_TICK) && pend_v;
                        tgt_oor    <= step_oor;
                        WallReq    <= !step_oor;
                        WallX      <= step_x;
                        WallY      <= step_y;
                    end
                end
                S_QUERY: begin
                    if (query_done) begin
                        WallReq <= 1'b0;
                        if (query_hit && !using_pend) Moving <= 1'b0;
                    end
                end
                S_MOVE: begin
                    // WallX/WallY still hold the accepted target.
                    pacX   <= WallX;
                    pacY   <= WallY;
                    Dir    <= try_dir;
                    Moving <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Qi = (state == S_INIT);
    assign Qw = (state == S_WAIT_TICK) || (state == S_QUERY) || (state == S_RETRY);
    assign Qm = (state == S_MOVE);

endmodule

// File: tb/tb_pacman_movement.sv
module tb_pacman_movement;

    logic       clk;
    logic       rst_n, start, up, down, left, right, wall_ack, wall_hit;
    logic       wall_req, moving, qi, qw, qm;
    logic [9:0] wall_x, wall_y, pac_x, pac_y;
    logic [1:0] dir;

    int errors = 0;
    int checks = 0;
    int req_cycles = 0;
    int wall_q_cnt = 0;
    logic [9:0] last_qx = '0, last_qy = '0;
    logic [9:0] wx[4], wy[4];
    bit         wen[4];

    pacman_movement #(.TICK_CYCLES(4)) dut (
        .Clk(clk), .Reset(rst_n), .Start(start),
        .SCEN_Up(up), .SCEN_Down(down), .SCEN_Left(left), .SCEN_Right(right),
        .WallReq(wall_req), .WallX(wall_x), .WallY(wall_y),
        .WallAck(wall_ack), .WallHit(wall_hit),
        .pacX(pac_x), .pacY(pac_y), .Dir(dir), .Moving(moving),
        .Qi(qi), .Qw(qw), .Qm(qm)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit is_wall(input logic [9:0] x, input logic [9:0] y);
        for (int i = 0; i < 4; i++)
            if (wen[i] && wx[i] == x && wy[i] == y) return 1'b1;
        return 1'b0;
    endfunction

    // Wall model: acknowledges every request one cycle after it appears.
    initial begin
        wall_ack = 1'b0;
        wall_hit = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (wall_req && !wall_ack) begin
                wall_ack = 1'b1;
                wall_hit = is_wall(wall_x, wall_y);
                last_qx  = wall_x;
                last_qy  = wall_y;
                if (wall_x == 10'd310 && wall_y == 10'd240) wall_q_cnt++;
            end else begin
                wall_ack = 1'b0;
                wall_hit = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (wall_req) req_cycles++;
    end

    task automatic clear_walls();
        for (int i = 0; i < 4; i++) wen[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0;
        up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic pulse(input bit u, input bit d, input bit l, input bit r);
        up = u; down = d; left = l; right = r;
        @(posedge clk);
        #1;
        up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    endtask

    // Waits for a MOVE cycle and returns just after the position update.
    task automatic wait_move(input int maxc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (qm) begin ok = 1'b1; break; end
        end
        checks++;
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            errors++;
            $display("FAIL move_timeout: no step within %0d cycles (pacX=%0d pacY=%0d)", maxc, pac_x, pac_y);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0;
        up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        clear_walls();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pac_x !== 10'd320) begin errors++; $display("FAIL rst_pacX: got %0d want 320", pac_x); end
        checks++; if (pac_y !== 10'd240) begin errors++; $display("FAIL rst_pacY: got %0d want 240", pac_y); end
        checks++; if (dir !== 2'b10) begin errors++; $display("FAIL rst_Dir: got %0d want 2", dir); end
        checks++; if (moving !== 1'b0) begin errors++; $display("FAIL rst_Moving: got %0b want 0", moving); end
        checks++; if (wall_req !== 1'b0) begin errors++; $display("FAIL rst_WallReq: got %0b want 0", wall_req); end
        checks++; if (wall_x !== 10'd0 || wall_y !== 10'd0) begin errors++; $display("FAIL rst_WallXY: got %0d,%0d want 0,0", wall_x, wall_y); end
        checks++; if ({qi, qw, qm} !== 3'b100) begin errors++; $display("FAIL rst_state: got %b want 100", {qi, qw, qm}); end
        checks++; if (dut.pend_v !== 1'b0) begin errors++; $display("FAIL rst_pend_v: got %0b want 0", dut.pend_v); end
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checks++; if (qi !== 1'b1) begin errors++; $display("FAIL init_hold: Qi got %0b want 1", qi); end
        checks++; if (pac_x !== 10'd320) begin errors++; $display("FAIL init_pacX: got %0d want 320", pac_x); end
        checks++; if (req_cycles !== 0) begin errors++; $display("FAIL init_noreq: got %0d want 0", req_cycles); end
    endtask

    task automatic test_left_run();
        do_reset();
        start = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            wait_move(20);
            checks++; if (pac_x !== 10'(320 - i)) begin errors++; $display("FAIL run_pacX: got %0d want %0d", pac_x, 320 - i); end
            checks++; if (pac_y !== 10'd240) begin errors++; $display("FAIL run_pacY: got %0d want 240", pac_y); end
            checks++; if (dir !== 2'b10 || moving !== 1'b1) begin errors++; $display("FAIL run_dir_mov: got %0d/%0b want 2/1", dir, moving); end
        end
        start = 1'b0;
        wait_move(20);
        checks++; if (pac_x !== 10'd316) begin errors++; $display("FAIL start_drop: pacX got %0d want 316", pac_x); end
    endtask

    task automatic test_turn_up();
        do_reset();
        start = 1'b1;
        wait_move(20);
        wait_move(20);
        checks++; if (pac_x !== 10'd318) begin errors++; $display("FAIL up_pre: pacX got %0d want 318", pac_x); end
        pulse(1, 0, 0, 0);
        wait_move(20);
        checks++; if (pac_y !== 10'd239 || pac_x !== 10'd318) begin errors++; $display("FAIL up_pos: got %0d,%0d want 318,239", pac_x, pac_y); end
        checks++; if (dir !== 2'b00) begin errors++; $display("FAIL up_dir: got %0d want 0", dir); end
        checks++; if (dut.pend_v !== 1'b0) begin errors++; $display("FAIL up_pend_clr: got %0b want 0", dut.pend_v); end
    endtask

    task automatic test_wall_stop();
        int moves;
        do_reset();
        clear_walls();
        wx[0] = 10'd310; wy[0] = 10'd240; wen[0] = 1'b1;
        wall_q_cnt = 0;
        start = 1'b1;
        repeat (9) wait_move(20);
        checks++; if (pac_x !== 10'd311) begin errors++; $display("FAIL wall_reach: pacX got %0d want 311", pac_x); end
        moves = 0;
        repeat (20) begin
            @(negedge clk);
            if (qm) moves++;
        end
        checks++; if (moves !== 0) begin errors++; $display("FAIL wall_nomove: got %0d steps want 0", moves); end
        checks++; if (pac_x !== 10'd311) begin errors++; $display("FAIL wall_hold: pacX got %0d want 311", pac_x); end
        checks++; if (moving !== 1'b0) begin errors++; $display("FAIL wall_moving: got %0b want 0", moving); end
        checks++; if (wall_q_cnt < 3) begin errors++; $display("FAIL wall_queries: got %0d want >=3", wall_q_cnt); end
        clear_walls();
    endtask

    task automatic test_blocked_turn();
        do_reset();
        clear_walls();
        wx[0] = 10'd318; wy[0] = 10'd241; wen[0] = 1'b1;
        start = 1'b1;
        wait_move(20);
        wait_move(20);
        pulse(0, 1, 0, 0);
        wait_move(30);
        checks++; if (pac_x !== 10'd317 || pac_y !== 10'd240) begin errors++; $display("FAIL blk_pos: got %0d,%0d want 317,240", pac_x, pac_y); end
        checks++; if (dir !== 2'b10) begin errors++; $display("FAIL blk_dir: got %0d want 2", dir); end
        checks++; if (dut.pend_v !== 1'b1) begin errors++; $display("FAIL blk_pend: got %0b want 1", dut.pend_v); end
        wait_move(30);
        checks++; if (pac_x !== 10'd317 || pac_y !== 10'd241) begin errors++; $display("FAIL turn_pos: got %0d,%0d want 317,241", pac_x, pac_y); end
        checks++; if (dir !== 2'b01) begin errors++; $display("FAIL turn_dir: got %0d want 1", dir); end
        checks++; if (dut.pend_v !== 1'b0) begin errors++; $display("FAIL turn_pend: got %0b want 0", dut.pend_v); end
        clear_walls();
    endtask

    task automatic test_priority_edge();
        int r;
        do_reset();
        start = 1'b1;
        wait_move(20);
        pulse(1, 0, 1, 0);
        wait_move(20);
        checks++; if (pac_y !== 10'd239 || pac_x !== 10'd319) begin errors++; $display("FAIL prio_pos: got %0d,%0d want 319,239", pac_x, pac_y); end
        checks++; if (dir !== 2'b00) begin errors++; $display("FAIL prio_dir: got %0d want 0", dir); end
        for (int k = 0; k < 260 && pac_y != 10'd0; k++) wait_move(20);
        checks++; if (pac_y !== 10'd0) begin errors++; $display("FAIL top_reach: pacY got %0d want 0", pac_y); end
        r = req_cycles;
        repeat (24) @(negedge clk);
        checks++; if (req_cycles !== r) begin errors++; $display("FAIL top_noquery: req cycles got %0d want %0d", req_cycles, r); end
        checks++; if (moving !== 1'b0 || pac_y !== 10'd0) begin errors++; $display("FAIL top_hold: Moving=%0b pacY=%0d want 0/0", moving, pac_y); end
    endtask

    task automatic test_reset_mid_query();
        bit seen;
        do_reset();
        start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wall_req) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL mq_req: WallReq got 0 want 1"); end
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (wall_req !== 1'b0) begin errors++; $display("FAIL mq_drop: WallReq got %0b want 0", wall_req); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (qi !== 1'b1 || wall_req !== 1'b0 || pac_x !== 10'd320) begin errors++; $display("FAIL mq_after: Qi=%0b WallReq=%0b pacX=%0d want 1/0/320", qi, wall_req, pac_x); end
    endtask

    task automatic test_tunnel();
        do_reset();
        start = 1'b1;
        for (int k = 0; k < 330 && pac_x != 10'd0; k++) wait_move(20);
        checks++; if (pac_x !== 10'd0 || pac_y !== 10'd240) begin errors++; $display("FAIL edge_reach: got %0d,%0d want 0,240", pac_x, pac_y); end
`ifdef PACMAN_TUNNEL_EN
        wait_move(20);
        checks++; if (pac_x !== 10'd639) begin errors++; $display("FAIL tunnel_x: got %0d want 639", pac_x); end
        checks++; if (last_qx !== 10'd639 || last_qy !== 10'd240) begin errors++; $display("FAIL tunnel_q: got %0d,%0d want 639,240", last_qx, last_qy); end
`else
        begin
            int moves;
            moves = 0;
            repeat (20) begin
                @(negedge clk);
                if (qm) moves++;
            end
            checks++; if (moves !== 0 || pac_x !== 10'd0) begin errors++; $display("FAIL edge_hold: steps=%0d pacX=%0d want 0/0", moves, pac_x); end
            checks++; if (moving !== 1'b0) begin errors++; $display("FAIL edge_moving: got %0b want 0", moving); end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_left_run();
        test_turn_up();
        test_wall_stop();
        test_blocked_turn();
        test_priority_edge();
        test_reset_mid_query();
        test_tunnel();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
